// File: rtl/mem_access_unit.sv
// Data-side memory access unit: runs one bus transaction per EXU load/store,
// stalls the EXU while it is in flight and returns an extended load result.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: bus_req and all bus_* fields stay stable until a cycle with
  // bus_gnt; exactly one bus_rvalid follows per granted request. Towards the
  // EXU, a request is taken when busy is low at the next edge, and resp_valid
  // is a single-cycle pulse with no backpressure.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  addr_lo;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        cancel;
  logic [31:0] tmo_cnt;

  logic        accept;
  logic        tmo_hit;
  logic        finish;
  logic        drop;
  logic        fault;
  logic [31:0] load_data;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  lo,
                                          input logic [1:0]  size,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    extract = {{24{~uns & b[7]}}, b};
      2'd1:    extract = {{16{~uns & h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  assign accept    = (state == IDLE) & (req_load | req_store) & ~flush;
  assign busy      = accept | (state == REQ) | (state == WAIT);
  assign dbg_state = state;

  // rvalid takes precedence over a timeout landing in the same cycle.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign finish    = bus_rvalid | tmo_hit;
  assign fault     = bus_rvalid ? bus_err : 1'b1;
  assign drop      = cancel | flush;
  assign load_data = extract(bus_rdata, addr_lo, size_q, uns_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wdata  <= 32'h0;
      addr_lo    <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      cancel     <= 1'b0;
      tmo_cnt    <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= req_store;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= req_mask;
            bus_wdata <= req_wdata;
            addr_lo   <= req_addr[1:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            cancel    <= 1'b0;
          end
        end
        REQ: begin
          if (flush) cancel <= 1'b1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            tmo_cnt <= 32'h0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (flush) cancel <= 1'b1;
          tmo_cnt <= tmo_cnt + 32'h1;
          if (finish) begin
            state      <= DONE;
            resp_valid <= ~drop;
            resp_err   <= ~drop & fault;
            resp_rdata <= (drop | fault | bus_we) ? 32'h0 : load_data;
          end
        end
        default: begin
          if (flush) cancel <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner
// sequences and randomized transactions against a reference model.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_load;
  logic        req_store;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [1:0]  dbg_state;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .busy(busy), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] rdata;
    bit          err;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  int cmp_count  = 0;
  int fail_count = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: response word {err, rdata} from the access rules.
  function automatic logic [32:0] ref_resp(input bit st, input logic [31:0] a,
                                           input logic [1:0] sz, input bit u,
                                           input logic [31:0] rd, input bit e,
                                           input bit timed_out);
    int unsigned v;
    int unsigned sh;
    if (timed_out || e) return {1'b1, 32'h0};
    if (st) return 33'h0;
    sh = a % 4;
    if (sz == 2'd0) begin
      v = (rd >> (8 * sh)) % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (sh / 2))) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return {1'b0, v};
  endfunction

  // driver: one full transaction with a scripted bus responder
  task automatic do_txn(input vec_t v, input bit flush_wait);
    bit timed_out;
    int done_k;
    logic [32:0] exp;
    timed_out = (TMO != 0) && (v.rv_dly > TMO - 1);
    done_k    = timed_out ? TMO - 1 : v.rv_dly;
    if (!flush_wait) exp_q.push_back({v.exp_err, v.exp_rdata});

    @(posedge clk); #1;
    req_load     = ~v.is_store;
    req_store    = v.is_store;
    req_addr     = v.addr;
    req_mask     = v.mask;
    req_wdata    = v.wdata;
    req_size     = v.size;
    req_unsigned = v.uns;
    #1;
    check("accept_busy", busy, 1);
    check("accept_no_bus_req", bus_req, 0);

    for (int k = 0; k <= v.gnt_dly; k++) begin
      @(posedge clk); #1;
      bus_gnt = (k == v.gnt_dly);
      #1;
      check("req_bus_req", bus_req, 1);
      check("req_busy", busy, 1);
      check("req_bus_we", bus_we, v.is_store);
      check("req_bus_addr", bus_addr, {v.addr[31:2], 2'b00});
      check("req_bus_be", bus_be, v.mask);
      check("req_bus_wdata", bus_wdata, v.wdata);
    end

    for (int k = 0; k <= done_k; k++) begin
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      flush   = flush_wait && (k == 0);
      if (k == v.rv_dly) begin
        bus_rvalid = 1'b1;
        bus_rdata  = v.rdata;
        bus_err    = v.err;
      end
      #1;
      check("wait_busy", busy, 1);
      check("wait_bus_req", bus_req, 0);
      check("wait_resp_valid", resp_valid, 0);
    end

    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    flush      = 1'b0;
    #1;
    check("done_busy", busy, 0);
    check("done_resp_valid", resp_valid, !flush_wait);
    if (!flush_wait && resp_valid) begin
      exp = exp_q.pop_front();
      check("done_resp_rdata", resp_rdata, exp[31:0]);
      check("done_resp_err", resp_err, exp[32]);
    end

    @(posedge clk); #1;
    req_load  = 1'b0;
    req_store = 1'b0;
    #1;
    check("after_resp_valid", resp_valid, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t        rv;
    logic [32:0] r;
    bit          to;

    vecs[0] = '{0, 32'h1003, 4'b1000, 32'h0, 2'd0, 0, 32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80, 0};
    vecs[1] = '{0, 32'h2002, 4'b1100, 32'h0, 2'd1, 1, 32'hBEEF_0001, 0, 0, 0, 32'h0000_BEEF, 0};
    vecs[2] = '{1, 32'h3001, 4'b0010, 32'h0000_AB00, 2'd0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0};
    vecs[3] = '{0, 32'h4000, 4'b1111, 32'h0, 2'd2, 0, 32'h1234_5678, 0, 4, 2, 32'h1234_5678, 0};
    vecs[4] = '{0, 32'h5004, 4'b1111, 32'h0, 2'd2, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'h0, 1};
    vecs[5] = '{0, 32'h6000, 4'b0011, 32'h0, 2'd1, 0, 32'h0000_8001, 0, 0, 1, 32'hFFFF_8001, 0};
    vecs[6] = '{0, 32'h7001, 4'b0010, 32'h0, 2'd0, 1, 32'h0000_C300, 0, 2, 0, 32'h0000_00C3, 0};
    vecs[7] = '{0, 32'h8000, 4'b1111, 32'h0, 2'd3, 0, 32'hA5A5_5A5A, 0, 0, 0, 32'hA5A5_5A5A, 0};
    vecs[8] = '{0, 32'h9000, 4'b1111, 32'h0, 2'd2, 0, 32'h1111_2222, 0, 0, TMO - 1, 32'h1111_2222, 0};
    vecs[9] = '{0, 32'hA000, 4'b1111, 32'h0, 2'd2, 0, 32'h0, 0, 0, 50, 32'h0, 1};

    // reset block
    rst = 1'b0; flush = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_addr = '0; req_mask = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;

    // vector table (last row times out)
    for (int i = 0; i < 10; i++) do_txn(vecs[i], 1'b0);

    // late rvalid in IDLE after the timeout
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    #1;
    check("late_rvalid_busy", busy, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    #1;
    check("late_rvalid_resp", resp_valid, 0);
    check("late_rvalid_state", dbg_state, 0);

    // flush in WAIT, then a normal LW
    do_txn('{0, 32'hB000, 4'b1111, 32'h0, 2'd2, 0, 32'hCAFE_F00D, 0, 0, 2, 32'h0, 0}, 1'b1);
    do_txn('{0, 32'hB004, 4'b1111, 32'h0, 2'd2, 0, 32'h0BAD_CAFE, 0, 0, 0, 32'h0BAD_CAFE, 0}, 1'b0);

    // flush together with a request in IDLE
    @(posedge clk); #1;
    req_load = 1'b1; req_addr = 32'hC000; flush = 1'b1;
    #1;
    check("flush_idle_busy", busy, 0);
    @(posedge clk); #1;
    req_load = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_bus_req", bus_req, 0);
    check("flush_idle_state", dbg_state, 0);

    // asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    req_load = 1'b1; req_addr = 32'hD000; req_mask = 4'hF; req_size = 2'd2;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #1;
    check("pre_rst_busy", busy, 1);
    #1;
    req_load = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_bus_addr", bus_addr, 0);
    check("async_rst_bus_be", bus_be, 0);
    check("async_rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("post_rst_state", dbg_state, 0);
    check("post_rst_bus_req", bus_req, 0);
    check("post_rst_resp_valid", resp_valid, 0);

    // randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      rv.is_store = ($urandom_range(0, 3) == 0);
      rv.size     = 2'($urandom_range(0, 3));
      rv.addr     = $urandom;
      if (rv.size == 2'd1) rv.addr[0] = 1'b0;
      if (rv.size[1]) rv.addr[1:0] = 2'b00;
      case (rv.size)
        2'd0:    rv.mask = 4'(1 << rv.addr[1:0]);
        2'd1:    rv.mask = rv.addr[1] ? 4'b1100 : 4'b0011;
        default: rv.mask = 4'b1111;
      endcase
      rv.wdata   = $urandom;
      rv.uns     = $urandom_range(0, 1);
      rv.rdata   = $urandom;
      rv.err     = ($urandom_range(0, 7) == 0);
      rv.gnt_dly = $urandom_range(0, 3);
      rv.rv_dly  = $urandom_range(0, 9);
      to = rv.rv_dly > TMO - 1;
      r = ref_resp(rv.is_store, rv.addr, rv.size, rv.uns, rv.rdata, rv.err, to);
      rv.exp_rdata = r[31:0];
      rv.exp_err   = r[32];
      do_txn(rv, 1'b0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
